// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Frame length in oversampling ticks, with the same nbits clamping as the transmitter.
    function automatic int frame_ticks(input int n_tick, input int nbits,
                                       input int data_bits_max,
                                       input bit par_en, input bit stop2);
        int nb;
        nb = (nbits == 0 || nbits > data_bits_max) ? data_bits_max : nbits;
        return n_tick * (1 + nb + (par_en ? 1 : 0) + (stop2 ? 2 : 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmitter, one frame per valid/ready handshake with
//               per-frame data length, parity and stop-bit settings.
//               Optional macro UART_TX_PARITY_EN builds the parity support.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS_MAX = 8,
    parameter int N_TICK        = 16
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset_n,
    input  logic                                 i_tick,
    input  logic [DATA_BITS_MAX-1:0]             i_data,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [$clog2(DATA_BITS_MAX+1)-1:0]   i_nbits,
    input  logic [1:0]                           i_parity,
    input  logic                                 i_stop2,
    output logic                                 o_tx,
    output logic                                 o_busy,
    output logic                                 o_done
);

    localparam int                c_NB_W      = $clog2(DATA_BITS_MAX + 1);
    localparam int                c_TW        = $clog2(N_TICK);
    localparam logic [c_TW-1:0]   c_TICK_LAST = c_TW'(N_TICK - 1);
    localparam logic [c_NB_W-1:0] c_NB_MAX    = c_NB_W'(DATA_BITS_MAX);

    uart_state_t              r_state;
    logic [c_TW-1:0]          r_tick_cnt;
    logic [c_NB_W-1:0]        r_bit_cnt;
    logic [c_NB_W-1:0]        r_nbits;
    logic [DATA_BITS_MAX-1:0] r_shift;
    logic                     r_stop2;
    logic                     r_tx;
    logic                     r_done;

    logic                     w_accept;
    logic                     w_bit_end;
    logic                     w_last_bit;
    logic [c_NB_W-1:0]        w_nbits_clamped;

    assign o_ready  = (r_state == IDLE);
    assign o_busy   = ~o_ready;
    assign o_tx     = r_tx;
    assign o_done   = r_done;

    assign w_accept        = i_valid && o_ready;
    assign w_bit_end       = i_tick && (r_tick_cnt == c_TICK_LAST);
    assign w_last_bit      = (r_bit_cnt == r_nbits - c_NB_W'(1));
    assign w_nbits_clamped = (i_nbits == '0 || i_nbits > c_NB_MAX) ? c_NB_MAX : i_nbits;

`ifdef UART_TX_PARITY_EN
    logic [1:0] r_par_mode;
    logic       r_par_acc;
    logic       w_par_en;
    logic       w_par_bit;

    assign w_par_en  = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
    // The final data bit is folded in here because the accumulator updates on the same edge.
    assign w_par_bit = r_par_acc ^ r_shift[0] ^ (r_par_mode == PAR_ODD);
`else
    logic w_unused_parity;
    assign w_unused_parity = ^i_parity;
`endif

    always_ff @(posedge i_clock) begin
        r_done <= 1'b0;
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_nbits    <= '0;
            r_stop2    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_mode <= PAR_NONE;
            r_par_acc  <= 1'b0;
`endif
        end else begin
            if (r_state != IDLE && i_tick)
                r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + c_TW'(1);

            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_shift    <= i_data;
                        r_nbits    <= w_nbits_clamped;
                        r_stop2    <= i_stop2;
`ifdef UART_TX_PARITY_EN
                        r_par_mode <= i_parity;
                        r_par_acc  <= 1'b0;
`endif
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + c_NB_W'(1);
`ifdef UART_TX_PARITY_EN
                        r_par_acc <= r_par_acc ^ r_shift[0];
`endif
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            if (w_par_en) begin
                                r_tx    <= w_par_bit;
                                r_state <= PARITY;
                            end else
`endif
                            begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    // The bit counter doubles as the stop-bit index for two-stop frames.
                    if (w_bit_end) begin
                        if (r_stop2 && r_bit_cnt == '0) begin
                            r_bit_cnt <= c_NB_W'(1);
                        end else begin
                            r_bit_cnt <= '0;
                            r_done    <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx       <= 1'b1;
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Self-checking bench for uart_tx_frame (N_TICK 16, 8 data bits,
//               tick every cycle); honours UART_TX_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int c_N_TICK = 16;
    localparam int c_DBM    = 8;
    localparam int c_NB_W   = $clog2(c_DBM + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick;
    logic [c_DBM-1:0]  data;
    logic              valid;
    logic              ready;
    logic [c_NB_W-1:0] nbits;
    logic [1:0]        parity;
    logic              stop2;
    logic              tx;
    logic              busy;
    logic              done;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.DATA_BITS_MAX(c_DBM), .N_TICK(c_N_TICK)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_tick    (tick),
        .i_data    (data),
        .i_valid   (valid),
        .o_ready   (ready),
        .i_nbits   (nbits),
        .i_parity  (parity),
        .i_stop2   (stop2),
        .o_tx      (tx),
        .o_busy    (busy),
        .o_done    (done)
    );

    typedef struct {
        logic [7:0]        data;
        logic [c_NB_W-1:0] nb;
        logic [1:0]        par;
        logic              st2;
        int                len_par;   // frame ticks with parity support built
        int                len_np;    // frame ticks without parity support
        logic              par_bit;   // expected parity bit when parity is sent
    } vec_t;

    typedef struct {
        logic [19:0] bits;
        int          len;
    } exp_t;

    exp_t sb[$];

    function automatic vec_t mk(input logic [7:0] d, input int nb, input logic [1:0] p,
                                input logic s2, input int lp, input int ln, input logic pb);
        vec_t v;
        v.data = d; v.nb = c_NB_W'(nb); v.par = p; v.st2 = s2;
        v.len_par = lp; v.len_np = ln; v.par_bit = pb;
        return v;
    endfunction

    function automatic exp_t model(input vec_t v);
        exp_t e;
        int   nbe;
        int   p;
        nbe = (v.nb == 0 || v.nb > c_DBM) ? c_DBM : int'(v.nb);
        e.bits = '0;
        p = 1;
        for (int i = 0; i < nbe; i++) begin
            e.bits[p] = v.data[i];
            p++;
        end
`ifdef UART_TX_PARITY_EN
        if (v.par == 2'b01 || v.par == 2'b10) begin
            e.bits[p] = v.par_bit;
            p++;
        end
        e.len = v.len_par;
`else
        e.len = v.len_np;
`endif
        e.bits[p] = 1'b1;
        p++;
        if (v.st2) e.bits[p] = 1'b1;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: an accept is visible at the negedge before the edge that takes it.
    initial begin : monitor
        exp_t e;
        bit   abandoned;
        forever begin
            @(negedge clk);
            check("idle_done_low", done, 1'b0);
            while (rst_n && valid && ready) begin
                if (sb.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                    break;
                end
                e = sb.pop_front();
                abandoned = 0;
                for (int j = 1; j <= e.len + 1; j++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        abandoned = 1;
                        break;
                    end
                    if (j <= e.len) begin
                        check($sformatf("tx_bit%0d", (j - 1) / c_N_TICK), tx, e.bits[(j - 1) / c_N_TICK]);
                        check("done_low_in_frame", done, 1'b0);
                        if (j == 1) check("busy_after_accept", busy, 1'b1);
                    end else begin
                        check("done_at_frame_end", done, 1'b1);
                        check("ready_at_frame_end", ready, 1'b1);
                    end
                end
                if (abandoned) break;
            end
        end
    end

    task automatic drive_frame(input vec_t v, input bit keep, output int t_acc);
        bit acc;
        int t;
        @(posedge clk); #1;
        data = v.data; nbits = v.nb; parity = v.par; stop2 = v.st2; valid = 1'b1;
        sb.push_back(model(v));
        acc = 0;
        t   = 0;
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = ready;
            @(posedge clk); #1;
            t++;
        end
        t_acc = cyc;
        if (!acc) check("accept_timeout", 0, 1);
        if (!keep) valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ready && t < 2000);
        if (!ready) check("idle_timeout", ready, 1'b1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t vecs[8];
        vec_t v;
        int   t1, t2, t3;

        vecs[0] = mk(8'hA5, 8, 2'b00, 1'b0, 160, 160, 1'b0);  // 8N1
        vecs[1] = mk(8'h03, 8, 2'b01, 1'b0, 176, 160, 1'b0);  // 8E1
        vecs[2] = mk(8'h03, 8, 2'b10, 1'b0, 176, 160, 1'b1);  // 8O1
        vecs[3] = mk(8'hC1, 7, 2'b10, 1'b1, 176, 160, 1'b1);  // 7O2
        vecs[4] = mk(8'h5A, 0, 2'b11, 1'b0, 160, 160, 1'b0);  // nbits 0 -> 8, mode 11 = none
        vecs[5] = mk(8'h1F, 5, 2'b01, 1'b0, 128, 112, 1'b1);  // 5E1
        vecs[6] = mk(8'h02, 2, 2'b10, 1'b1,  96,  80, 1'b0);  // 2O2
        vecs[7] = mk(8'hFF, 12, 2'b01, 1'b0, 176, 160, 1'b0); // nbits > 8 -> 8

        rst_n = 1'b0; tick = 1'b1; valid = 1'b0; data = '0;
        nbits = c_NB_W'(8); parity = 2'b00; stop2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_ready", ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_tx", tx, 1'b1);

        for (int i = 0; i < 8; i++) begin
            drive_frame(vecs[i], 1'b0, t1);
            wait_idle();
        end

        // Valid held across three words: accepts land exactly in the o_done cycles.
        drive_frame(mk(8'h11, 8, 2'b00, 1'b0, 160, 160, 1'b0), 1'b1, t1);
        drive_frame(mk(8'h22, 8, 2'b00, 1'b0, 160, 160, 1'b0), 1'b1, t2);
        drive_frame(mk(8'h33, 8, 2'b00, 1'b0, 160, 160, 1'b0), 1'b0, t3);
        check("b2b_gap_1_2", t2 - t1, 161);
        check("b2b_gap_2_3", t3 - t2, 161);
        wait_idle();

        // Valid pulsed while busy must not be accepted.
        drive_frame(vecs[0], 1'b0, t1);
        repeat (30) @(posedge clk);
        #1;
        check("busy_not_ready", ready, 1'b0);
        data = 8'h00; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        wait_idle();

        // Config inputs changed mid-frame leave the frame in flight unchanged.
        drive_frame(vecs[1], 1'b0, t1);
        repeat (50) @(posedge clk);
        #1;
        parity = 2'b10; stop2 = 1'b1; nbits = c_NB_W'(3); data = 8'hFF;
        wait_idle();

        // Reset during data bit 3 abandons the frame.
        v = vecs[0];
        drive_frame(v, 1'b0, t1);
        repeat (68) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_tx", tx, 1'b1);
        check("midreset_ready", ready, 1'b1);
        check("midreset_busy", busy, 1'b0);
        check("midreset_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("midreset_still_idle", ready, 1'b1);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one word per valid/ready handshake. Data length, parity mode and stop-bit count are selected at run time. Each frame's settings are captured together with its data. The block sits between the command/FIFO logic and the pad and shares the external oversampling tick generator with the UART receiver.

## Interface
- DATA_BITS_MAX, 8: widest supported data field; legal 5..16
- N_TICK, 16: oversampling ticks per bit; legal ≥ 2
- i_clock  in  1  system clock; all logic on rising edge
- i_reset_n  in  1  synchronous, active-low reset
- i_tick  in  1  oversampling strobe, one i_clock wide, N_TICK per bit period
- i_data  in  DATA_BITS_MAX  word to send, LSB first; bits above the selected length ignored
- i_valid  in  1  i_data and config valid
- o_ready  out  1  block can accept a frame
- i_nbits  in  $clog2(DATA_BITS_MAX+1)  data length in bits
- i_parity  in  2  00 none, 01 even, 10 odd, 11 none
- i_stop2  in  1  1 = two stop bits, 0 = one
- o_tx  out  1  serial line, idle high, registered
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, START, DATA, PARITY, STOP; state encoding lives in the package.
- Accept condition: i_valid && o_ready in IDLE.
  - Latches i_data into the shift register.
  - Latches i_nbits, i_parity and i_stop2 into config registers; later input changes do not affect the frame in flight.
  - Clears the tick and bit counters and moves to START.
- i_nbits clamping: 0 or > DATA_BITS_MAX is treated as DATA_BITS_MAX; 1..4 is legal.
- START: o_tx = 0 for N_TICK ticks, then DATA.
- DATA: o_tx = shift[0].
  - After N_TICK ticks: shift right, increment the bit counter, fold the bit into a parity accumulator (XOR).
  - After bit nbits-1 the next state is PARITY if parity is enabled, else STOP.
- PARITY: o_tx = acc for even parity, ~acc for odd parity, held N_TICK ticks.
- STOP: o_tx = 1 for N_TICK ticks, or 2·N_TICK if stop2; then IDLE with o_done pulsed.
- Bit end: i_tick high with tick counter == N_TICK-1. The counter wraps to 0 on the same edge.
- Ticks not coinciding with a bit end increment the counter. Cycles without i_tick hold all counters.
- o_ready = (state == IDLE); o_busy = !o_ready.
- Illegal state encoding: return to IDLE, o_tx = 1, counters cleared.

## Timing
- Reset (i_reset_n low at an edge) forces:
  - state IDLE, o_tx = 1, o_ready = 1, o_busy = 0, o_done = 0;
  - counters and shift register 0.
- Reset mid-frame abandons the frame: o_tx is high from the next cycle and no o_done is produced.
- Accept at edge k: o_tx = 0 and o_busy = 1 from cycle k+1.
- The start bit lasts until the N_TICK-th following tick, so its length is ≤ one tick period longer than nominal.
- Frame length in ticks: N_TICK·(1 + nbits + P + S), where:
  - P = 1 with parity enabled, else 0;
  - S = 2 with stop2, else 1.
- o_done is high for exactly the cycle after the final stop tick; o_ready rises in that same cycle.
- Back-to-back frames: an accept can occur in the o_done cycle. The new start bit then follows the stop bit with no extra idle time.
- i_valid while busy is ignored and not queued; the source holds it until o_ready.

## Configuration
- UART_TX_PARITY_EN defined: i_parity is honoured and the PARITY state exists.
- UART_TX_PARITY_EN undefined:
  - PARITY state, parity accumulator and config bits are not built;
  - i_parity is ignored and frames are always sent without parity.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - a frame-length helper function for the bench.
- No sub-module: the tick counter, bit counter and parity are a few registers each. A single module of roughly 200 lines.

## Test plan
All scenarios use N_TICK = 16, DATA_BITS_MAX = 8 and i_tick high every cycle.
- 8N1 with 0xA5 → o_tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; o_done 160 cycles after accept.
- 8E1 with 0x03 → parity bit 0; 8O1 with 0x03 → parity bit 1; frame is 176 cycles.
- 7O2 with 0xC1 → data 1,0,0,0,0,0,1; bit 7 is never sent; parity bit 1; 11 bits = 176 cycles.
- Config changes:
  - i_nbits = 0 → frame sent as 8 bits;
  - i_parity/i_stop2 toggled mid-frame → current frame unchanged.
- Handshake:
  - i_valid held high across three words → accepts only in o_done cycles, with no idle gap between frames;
  - i_valid pulsed while busy → not accepted.
- Reset and macro:
  - i_reset_n low during DATA bit 3 → next cycle o_tx = 1, o_ready = 1, no o_done;
  - rebuilt without UART_TX_PARITY_EN, 8E1 0x03 → 160-cycle frame with no parity bit.
